rvv_fifo2w_push_sched: RTL

- Round-robin push scheduler in front of an 8-entry, 2-write/2-read open FIFO. The FIFO is built from two interleaved 4-entry banks.
- Takes up to NREQ independent valid/ready requesters and grants at most two entries per cycle.
- Drives registered push0/push1 beats with the mandatory ordering: push1 only with push0.
- Tracks free FIFO slots with an internal credit counter, so registered pushes never overflow the FIFO.

---
 rtl/rvv_fifo2w_push_sched.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rvv_fifo2w_push_sched.sv
// rtl/rvv_fifo2w_push_sched.sv - round-robin 2-wide push scheduler with credit tracking for an 8-entry 2W/2R FIFO
// Optional stall counter: define RVV_PUSH_SCHED_PERF_EN.
module rvv_fifo2w_push_sched #(
  parameter int DWIDTH = 32,
  parameter int NREQ   = 4,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  input  logic                   pop0,
  input  logic                   pop1,
  output logic                   push0,
  output logic [DWIDTH-1:0]      inData0,
  output logic                   push1,
  output logic [DWIDTH-1:0]      inData1,
  output logic [3:0]             credits,
  output logic                   sched_idle
`ifdef RVV_PUSH_SCHED_PERF_EN
  ,
  input  logic                   stall_clr,
  output logic [15:0]            stall_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] rr_next;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] a_idx;
  logic [PW-1:0] b_idx;
  logic          a_found;
  logic          b_found;
  logic          a_gnt;
  logic          b_gnt;
  logic [1:0]    ngrant;
  logic [1:0]    want;
  logic [4:0]    credits_sum;
  logic [DWIDTH-1:0] a_data;
  logic [DWIDTH-1:0] b_data;

  // First two valid requesters in cyclic order starting at rr_ptr.
  always_comb begin
    a_found  = 1'b0;
    b_found  = 1'b0;
    a_idx    = '0;
    b_idx    = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % NREQ);
      if (req_valid[scan_idx]) begin
        if (!a_found) begin
          a_found = 1'b1;
          a_idx   = scan_idx;
        end else if (!b_found) begin
          b_found = 1'b1;
          b_idx   = scan_idx;
        end
      end
    end
  end

  // Grants use only the registered credit count; same-cycle pops are not visible.
  assign a_gnt  = a_found && (credits != 4'd0);
  assign b_gnt  = b_found && (credits >= 4'd2);
  assign ngrant = {1'b0, a_gnt} + {1'b0, b_gnt};
  assign want   = b_found ? 2'd2 : (a_found ? 2'd1 : 2'd0);

  always_comb begin
    req_ready = '0;
    if (a_gnt) req_ready[a_idx] = 1'b1;
    if (b_gnt) req_ready[b_idx] = 1'b1;
  end

  always_comb begin
    rr_next = rr_ptr;
    if (b_gnt)      rr_next = PW'((int'(b_idx) + 1) % NREQ);
    else if (a_gnt) rr_next = PW'((int'(a_idx) + 1) % NREQ);
  end

  assign a_data      = req_data[int'(a_idx)*DWIDTH +: DWIDTH];
  assign b_data      = req_data[int'(b_idx)*DWIDTH +: DWIDTH];
  assign credits_sum = {1'b0, credits} - {3'b000, ngrant} + {4'b0000, pop0} + {4'b0000, pop1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      push0   <= 1'b0;
      push1   <= 1'b0;
      inData0 <= '0;
      inData1 <= '0;
      credits <= 4'(DEPTH);
      rr_ptr  <= '0;
    end else begin
      push0   <= a_gnt;
      push1   <= b_gnt;
      if (a_gnt) inData0 <= a_data;
      if (b_gnt) inData1 <= b_data;
      credits <= credits_sum[3:0];
      rr_ptr  <= rr_next;
    end
  end

  // push1 implies push0, so push0 alone tells whether a beat is pending.
  assign sched_idle = (credits == 4'(DEPTH)) && !push0;

`ifdef RVV_PUSH_SCHED_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall_clr) begin
      stall_cnt <= '0;
    end else if (|req_valid && (ngrant < want) && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

`ifdef ASSERT_ON
  // An underflowing sum wraps above DEPTH in 5 bits, so one bound covers both directions.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rvv_expect_pop_order: assert (!(pop1 && !pop0))
        else $error("pop1 without pop0");
      rvv_expect_credit_range: assert (credits_sum <= 5'(DEPTH))
        else $error("credit counter out of range");
    end
  end
`endif

endmodule
